// File: rtl/svmrow_sched.sv
// Frame sequencer for svmrow_mem: gates one window-row set of pixels into the accumulator,
// steps the coefficient ROM address, then runs the bypass/drain phase and counts result beats.
module svmrow_sched #(
    parameter int unsigned BLOCKSIZE  = 8,
    parameter int unsigned WPI        = 8,
    parameter int unsigned WINCOLS    = 8,
    parameter int unsigned WINROWS    = 16,
    parameter int unsigned DRAIN_TIME = WPI * WINCOLS + 15,
    localparam int unsigned NPIX      = BLOCKSIZE * WPI * WINCOLS * WINROWS,
    localparam int unsigned NCOEF     = BLOCKSIZE * WINCOLS * WINROWS,
    localparam int unsigned NRES      = WPI * WINCOLS,
    localparam int unsigned WCW       = $clog2(WPI),
    localparam int unsigned CAW       = $clog2(NCOEF),
    localparam int unsigned RIW       = $clog2(NRES) + 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic           continuous,
    input  logic           abort,
    input  logic           dvi_in,
    output logic           in_ready,
    output logic           svm_dvi,
    input  logic [WCW-1:0] wincount,
    output logic [CAW-1:0] coeff_addr,
    output logic           svm_bypass,
    input  logic           svm_dvo,
    output logic [RIW-1:0] res_idx,
    output logic           busy,
    output logic           frame_done,
    output logic           res_err,
    output logic           drop_err
);

    localparam int unsigned PCW = $clog2(NPIX);
    localparam int unsigned DCW = $clog2(DRAIN_TIME);

    localparam logic [PCW-1:0] PIX_LAST   = PCW'(NPIX - 1);
    localparam logic [CAW-1:0] COEF_LAST  = CAW'(NCOEF - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIME - 1);
    localparam logic [RIW-1:0] RES_FULL   = RIW'(NRES);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_t;

    state_t         state_q;
    logic [PCW-1:0] pix_cnt;
    logic [DCW-1:0] drain_cnt;
    logic           drop_seen;

    assign in_ready   = (state_q == StLoad);
    assign svm_dvi    = dvi_in & in_ready;
    assign busy       = (state_q != StIdle);
    assign frame_done = (state_q == StDone);

    // Pixels offered after the frame is complete are lost; IDLE is exempt.
    assign drop_seen  = dvi_in && (state_q == StDrain || state_q == StDone);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pix_cnt    <= '0;
            coeff_addr <= '0;
            drain_cnt  <= '0;
            res_idx    <= '0;
            svm_bypass <= 1'b0;
            res_err    <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            if (drop_seen) begin
                drop_err <= 1'b1;
            end
            if (abort) begin
                state_q    <= StIdle;
                pix_cnt    <= '0;
                coeff_addr <= '0;
                drain_cnt  <= '0;
                res_idx    <= '0;
                svm_bypass <= 1'b0;
            end else begin
                // Later assignments in the case below override this when counters clear.
                if (state_q != StIdle && svm_dvo && res_idx != RES_FULL) begin
                    res_idx <= res_idx + 1'b1;
                end
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q    <= StLoad;
                            pix_cnt    <= '0;
                            coeff_addr <= '0;
                            drain_cnt  <= '0;
                            res_idx    <= '0;
                            res_err    <= 1'b0;
                            drop_err   <= 1'b0;
                        end
                    end
                    StLoad: begin
                        if (svm_dvi) begin
                            pix_cnt <= pix_cnt + 1'b1;
                            if (wincount == '0) begin
                                coeff_addr <= (coeff_addr == COEF_LAST) ? '0
                                                                        : coeff_addr + 1'b1;
                            end
                            if (pix_cnt == PIX_LAST) begin
                                state_q    <= StDrain;
                                svm_bypass <= 1'b1;
                            end
                        end
                    end
                    StDrain: begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state_q    <= StDone;
                            svm_bypass <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    StDone: begin
                        if (res_idx != RES_FULL) begin
                            res_err <= 1'b1;
                        end
                        if (continuous) begin
                            state_q    <= StLoad;
                            pix_cnt    <= '0;
                            coeff_addr <= '0;
                            drain_cnt  <= '0;
                            res_idx    <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/svmrow_sched.md
Name: svmrow_sched

Overview:
- Frame-level sequencer for the svmrow_mem SVM row accumulator.
- Gates the upstream pixel stream into the accumulator for exactly one window-row set.
- Generates the coefficient-memory read address, then drives the bypass/drain phase while counting result beats.
- Sits between the pixel source plus coefficient ROM on one side and svmrow_mem on the other; reports completion and errors to the slicevm control registers.

Parameters:
BLOCKSIZE, 8, pixels per block
WPI, 8, windows processed in parallel (interleave factor)
WINCOLS, 8, blocks per window row
WINROWS, 16, rows per window
DRAIN_TIME, WPI*WINCOLS+15, bypass cycles after the last pixel
NPIX (local), BLOCKSIZE*WPI*WINCOLS*WINROWS, pixels per frame (8192)
NCOEF (local), BLOCKSIZE*WINCOLS*WINROWS, coefficients per frame (1024)
NRES (local), WPI*WINCOLS, results per frame (64)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a frame when idle
continuous  in  1  when 1, DONE returns to LOAD instead of IDLE
abort  in  1  synchronous; returns to IDLE
dvi_in  in  1  upstream pixel valid
in_ready  out  1  scheduler accepts pixels (combinational, state==LOAD)
svm_dvi  out  1  dvi_in & in_ready, to svmrow_mem.dvi_in
wincount  in  $clog2(WPI)  phase from svmrow_mem
coeff_addr  out  $clog2(NCOEF)  coefficient ROM read address
svm_bypass  out  1  to svmrow_mem.dvi_bypass
svm_dvo  in  1  result valid from svmrow_mem
res_idx  out  $clog2(NRES)+1  index of the current result beat (valid with svm_dvo)
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse in DONE
res_err  out  1  sticky; wrong result count at end of frame
drop_err  out  1  sticky; dvi_in seen while in_ready=0 and state!=IDLE

Behaviour:
- Reset values: all registered outputs are 0, and state is IDLE. Counters pix_cnt, coeff_addr, drain_cnt and res_idx are all 0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD next cycle.
  - The same edge clears pix_cnt, coeff_addr, drain_cnt and res_idx.
  - res_err and drop_err are cleared only by start in IDLE.
- LOAD: each cycle with svm_dvi=1:
  - pix_cnt += 1.
  - If wincount==0, coeff_addr += 1, wrapping NCOEF-1 -> 0.
  - When the accepted pixel has pix_cnt==NPIX-1, go to DRAIN next cycle; in_ready drops that same next cycle.
  - No pixel beyond NPIX is ever forwarded.
- DRAIN:
  - svm_bypass=1 (registered: asserts the first DRAIN cycle).
  - drain_cnt counts 0..DRAIN_TIME-1; at DRAIN_TIME-1, go to DONE.
  - svm_bypass is 0 in DONE.
- Result counting, in any state except IDLE: svm_dvo=1 -> res_idx += 1, saturating at NRES. res_idx presents the pre-increment value alongside svm_dvo.
- DONE (1 cycle):
  - frame_done=1.
  - If res_idx != NRES, set res_err.
  - Go to LOAD if continuous=1 (counters cleared as on start), else go to IDLE.
- abort, any state: next state IDLE; counters cleared; svm_bypass=0; no frame_done pulse. abort takes priority over start and every other transition.
- start while busy is ignored.
- drop_err: sets the cycle after dvi_in=1 occurs with state in {DRAIN, DONE}; ignored in IDLE.
- Reset mid-frame: immediate return to reset values, asynchronously.
- Latency: svm_dvi has 0 cycles from dvi_in. The first bypass cycle is 1 cycle after the last accepted pixel.

Test Plan:
- Nominal frame:
  - Stimulus: start, random dvi_in ~50% duty, wincount from a modulo-8 model, 64 svm_dvo beats during DRAIN.
  - Required: exactly 8192 svm_dvi pulses; coeff_addr ends at 8192/8 mod 1024 = 0; svm_bypass high for exactly 79 cycles; frame_done once; res_err=0.
- Over-supply: hold dvi_in=1 continuously past the frame. Required: svm_dvi count = 8192; drop_err=1 the cycle after the first DRAIN cycle with dvi_in=1.
- Short result burst: only 60 svm_dvo beats in DRAIN. Required: res_err=1 at frame_done. With 70 beats, res_idx saturates at 64 and res_err=0.
- Continuous mode: continuous=1, two frames back-to-back. Required: two frame_done pulses; LOAD resumes the cycle after DONE; coeff_addr restarts at 0.
- Abort: abort at pix_cnt=3000. Required: busy=0 the next cycle; svm_dvi=0; no frame_done. A new start then yields a full 8192-pixel frame.
- Asynchronous reset mid-DRAIN: reset_n low for 1.5 cycles. Required: svm_bypass, busy and all counters are 0 immediately (not at the next edge).
